// File: rtl/aes_round_sequencer.sv
// Iterative AES-256 round sequencer: arbitrates two block requesters onto one shared
// combinational round datapath, steps it through rounds 0..NROUNDS and returns the result.
module aes_round_sequencer #(
  parameter int unsigned NROUNDS = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_data,
  input  logic         req0_encdec,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_data,
  input  logic         req1_encdec,
  output logic [127:0] rnd_state,
  output logic [3:0]   rnd_key_idx,
  output logic         rnd_first,
  output logic         rnd_last,
  output logic         rnd_dec,
  input  logic [127:0] rnd_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_id,
  output logic         busy
);

  localparam logic [3:0] LastRound = 4'(NROUNDS);

  typedef enum logic [1:0] {StIdle, StRun, StDone} fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [3:0]   r_q, r_d;
  logic         mode_q, mode_d;
  logic         id_q, id_d;
  logic         last_grant_q, last_grant_d;
  logic [127:0] state_q, state_d;
  logic [127:0] out_data_q, out_data_d;
  logic         out_valid_q, out_valid_d;

  logic grant0, grant1, in_run, is_last;

  // On contention the requester not served last wins.
  assign grant0 = req0_valid & (~req1_valid | last_grant_q);
  assign grant1 = req1_valid & (~req0_valid | ~last_grant_q);

  assign req0_ready = ~rst & (fsm_q == StIdle) & grant0;
  assign req1_ready = ~rst & (fsm_q == StIdle) & grant1;

  assign in_run  = (fsm_q == StRun);
  assign is_last = (r_q == LastRound);

  assign rnd_state   = in_run ? state_q : '0;
  assign rnd_key_idx = in_run ? (mode_q ? r_q : LastRound - r_q) : '0;
  assign rnd_first   = in_run & (r_q == 4'd0);
  assign rnd_last    = in_run & is_last;
  assign rnd_dec     = in_run & ~mode_q;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = id_q;
  assign busy      = (fsm_q != StIdle);

  always_comb begin
    fsm_d        = fsm_q;
    r_d          = r_q;
    mode_d       = mode_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    state_d      = state_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    unique case (fsm_q)
      StIdle: begin
        if (grant0) begin
          state_d      = req0_data;
          mode_d       = req0_encdec;
          id_d         = 1'b0;
          last_grant_d = 1'b0;
          r_d          = 4'd0;
          fsm_d        = StRun;
        end else if (grant1) begin
          state_d      = req1_data;
          mode_d       = req1_encdec;
          id_d         = 1'b1;
          last_grant_d = 1'b1;
          r_d          = 4'd0;
          fsm_d        = StRun;
        end
      end
      StRun: begin
        state_d = rnd_result;
        if (is_last) begin
          out_data_d  = rnd_result;
          out_valid_d = 1'b1;
          fsm_d       = StDone;
        end else begin
          r_d = r_q + 4'd1;
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          fsm_d       = StIdle;
        end
      end
      default: fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q        <= StIdle;
      r_q          <= 4'd0;
      mode_q       <= 1'b0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      state_q      <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      r_q          <= r_d;
      mode_q       <= mode_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      state_q      <= state_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: emulates the AES round datapath and key store, and checks
// results against a whole-block AES-256 reference plus directed arbitration/timing steps.
module tb_aes_round_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req0_encdec;
  logic         req1_valid, req1_ready, req1_encdec;
  logic [127:0] req0_data, req1_data;
  logic [127:0] rnd_state, rnd_result, out_data;
  logic [3:0]   rnd_key_idx;
  logic         rnd_first, rnd_last, rnd_dec;
  logic         out_valid, out_ready, out_id, busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic [127:0] rkey  [16];

  localparam logic [127:0] Pt = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] Ct = 128'h8ea2b7ca516745bfeafc49904b496089;

  aes_round_sequencer #(.NROUNDS(14)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_data(req0_data), .req0_encdec(req0_encdec),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_data(req1_data), .req1_encdec(req1_encdec),
    .rnd_state(rnd_state), .rnd_key_idx(rnd_key_idx), .rnd_first(rnd_first),
    .rnd_last(rnd_last), .rnd_dec(rnd_dec), .rnd_result(rnd_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_id(out_id), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- AES primitives ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [7:0]   b;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      b = s[127-8*i -: 8];
      o[127-8*i -: 8] = inv ? isbox[b] : sbox[b];
    end
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int src;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c - r + 4) % 4 : (c + r) % 4;
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*src+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [7:0]   a [4];
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    o = '0;
    if (inv) begin
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    end else begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = s[127-8*(4*c+j) -: 8];
      for (int i = 0; i < 4; i++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef[(j - i + 4) % 4], a[j]);
        o[127-8*(4*c+i) -: 8] = acc;
      end
    end
    return o;
  endfunction

  // One round of the external datapath, driven purely by the rnd_* control outputs.
  function automatic logic [127:0] dp_round(input logic [127:0] st, input logic [3:0] k,
                                            input logic first, input logic last,
                                            input logic dec);
    logic [127:0] t;
    if (first) return st ^ rkey[k];
    if (!dec) begin
      t = shift_rows(sub_bytes(st, 1'b0), 1'b0);
      if (!last) t = mix_columns(t, 1'b0);
      return t ^ rkey[k];
    end
    t = sub_bytes(shift_rows(st, 1'b1), 1'b1) ^ rkey[k];
    if (!last) t = mix_columns(t, 1'b1);
    return t;
  endfunction

  // Whole-block AES-256 cipher / inverse cipher.
  function automatic logic [127:0] aes_ref(input logic [127:0] blk, input logic enc);
    logic [127:0] s;
    if (enc) begin
      s = blk ^ rkey[0];
      for (int r = 1; r <= 14; r++) begin
        s = shift_rows(sub_bytes(s, 1'b0), 1'b0);
        if (r < 14) s = mix_columns(s, 1'b0);
        s = s ^ rkey[r];
      end
    end else begin
      s = blk ^ rkey[14];
      for (int r = 13; r >= 0; r--) begin
        s = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ rkey[r];
        if (r > 0) s = mix_columns(s, 1'b1);
      end
    end
    return s;
  endfunction

  task automatic build_tables();
    logic [7:0] p, inv, s;
    for (int x = 0; x < 256; x++) begin
      p = 8'h01;
      inv = 8'h00;
      if (x != 0) begin
        for (int k = 0; k < 254; k++) p = gmul(p, 8'(x));
        inv = p;
      end
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[x]  = s;
      isbox[s] = 8'(x);
    end
  endtask

  task automatic expand_key(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        t = subword(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) rkey[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    rkey[15] = '0;
  endtask

  assign rnd_result = dp_round(rnd_state, rnd_key_idx, rnd_first, rnd_last, rnd_dec);

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    @(negedge clk);
    for (int k = 0; k < 60 && !(req0_ready | req1_ready); k++) @(negedge clk);
    check(tag, 128'(req0_ready | req1_ready), 128'(1));
  endtask

  task automatic wait_ov(input string tag);
    @(negedge clk);
    for (int k = 0; k < 60 && !out_valid; k++) @(negedge clk);
    check(tag, 128'(out_valid), 128'(1));
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [128:0] exp_q [$];
  int           acc_q [$];
  logic         prev_ov = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
    end else begin
      if (req0_valid & req0_ready) begin
        exp_q.push_back({1'b0, aes_ref(req0_data, req0_encdec)});
        acc_q.push_back(cyc + 1);
      end
      if (req1_valid & req1_ready) begin
        exp_q.push_back({1'b1, aes_ref(req1_data, req1_encdec)});
        acc_q.push_back(cyc + 1);
      end
      if (out_valid & !prev_ov) begin
        if (exp_q.size() == 0) check("spurious_out_valid", 128'(out_valid), 128'(0));
        else check("latency", 128'(cyc), 128'(acc_q[0] + 15));
      end
      if (out_valid & out_ready & (exp_q.size() != 0)) begin
        check("sb_out_data", out_data, exp_q[0][127:0]);
        check("sb_out_id", 128'(out_id), 128'(exp_q[0][128]));
        void'(exp_q.pop_front());
        void'(acc_q.pop_front());
      end
    end
    prev_ov <= out_valid & ~rst;
  end

  // ---------------- directed + random sequence ----------------
  logic [127:0] d0, exp_bp;
  logic         e0, a0, a1;
  int           last_acc;

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_data = '0; req0_encdec = 1'b0;
    req1_valid = 1'b0; req1_data = '0; req1_encdec = 1'b0;
    out_ready = 1'b1;
    build_tables();
    expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);

    // Reset with both requesters asserting
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    tick();
    @(negedge clk);
    check("rst_readys", 128'({req0_ready, req1_ready}), 128'(0));
    check("rst_busy_ov", 128'({busy, out_valid, out_id}), 128'(0));
    check("rst_rnd_ctl", 128'({rnd_key_idx, rnd_first, rnd_last, rnd_dec}), 128'(0));
    check("rst_rnd_state", rnd_state, '0);
    check("rst_out_data", out_data, '0);
    tick();
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Encrypt known-answer vector via req0
    req0_data = Pt; req0_encdec = 1'b1; req0_valid = 1'b1;
    @(negedge clk);
    check("enc_ready", 128'({req0_ready, req1_ready}), 128'(2'b10));
    tick();
    req0_valid = 1'b0;
    for (int r = 0; r <= 14; r++) begin
      @(negedge clk);
      check("enc_rnd_ctl", 128'({busy, rnd_key_idx, rnd_first, rnd_last, rnd_dec}),
            128'({1'b1, 4'(r), r == 0, r == 14, 1'b0}));
    end
    @(negedge clk);
    check("enc_ov", 128'(out_valid), 128'(1));
    check("enc_data", out_data, Ct);
    check("enc_id", 128'(out_id), 128'(0));
    tick();

    // Decrypt known-answer vector via req1
    req1_data = Ct; req1_encdec = 1'b0; req1_valid = 1'b1;
    @(negedge clk);
    check("dec_ovlow_idle", 128'({out_valid, busy}), 128'(0));
    check("dec_ready", 128'({req0_ready, req1_ready}), 128'(2'b01));
    tick();
    req1_valid = 1'b0;
    for (int r = 0; r <= 14; r++) begin
      @(negedge clk);
      check("dec_rnd_ctl", 128'({busy, rnd_key_idx, rnd_first, rnd_last, rnd_dec}),
            128'({1'b1, 4'(14 - r), r == 0, r == 14, 1'b1}));
    end
    @(negedge clk);
    check("dec_ov", 128'(out_valid), 128'(1));
    check("dec_data", out_data, Pt);
    check("dec_id", 128'(out_id), 128'(1));
    tick();

    // Both requesters valid continuously after reset
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    req0_data = rand128(); req0_encdec = 1'($urandom_range(0, 1)); req0_valid = 1'b1;
    req1_data = rand128(); req1_encdec = 1'($urandom_range(0, 1)); req1_valid = 1'b1;
    last_acc = 0;
    for (int g = 0; g < 4; g++) begin
      wait_ready("alt_wait");
      check("alt_grant", 128'({req0_ready, req1_ready}), 128'((g % 2 == 0) ? 2'b10 : 2'b01));
      if (g > 0) check("alt_gap", 128'(cyc - last_acc), 128'(17));
      last_acc = cyc;
      tick();
      if (g % 2 == 0) req0_data = rand128();
      else req1_data = rand128();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (20) tick();

    // Backpressure on the result with req1 waiting
    d0 = rand128(); e0 = 1'($urandom_range(0, 1));
    req0_data = d0; req0_encdec = e0; req0_valid = 1'b1; out_ready = 1'b0;
    wait_ready("bp_wait_ready");
    tick();
    req0_valid = 1'b0;
    req1_data = rand128(); req1_encdec = 1'($urandom_range(0, 1)); req1_valid = 1'b1;
    exp_bp = aes_ref(d0, e0);
    wait_ov("bp_wait_ov");
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_ov", 128'(out_valid), 128'(1));
      check("bp_data", out_data, exp_bp);
      check("bp_id", 128'(out_id), 128'(0));
      check("bp_readys", 128'({req0_ready, req1_ready}), 128'(0));
      if (i == 4) begin
        tick();
        out_ready = 1'b1;
      end
    end
    @(negedge clk);
    check("bp_req1_ready", 128'({out_valid, req0_ready, req1_ready}), 128'(3'b001));
    tick();
    req1_valid = 1'b0;
    repeat (20) tick();

    // Reset pulse while in RUN at r=7
    req0_data = rand128(); req0_encdec = 1'b1; req0_valid = 1'b1;
    wait_ready("rr_wait_ready");
    tick();
    req0_valid = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    req0_data = rand128(); req1_data = rand128();
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    check("rr_r7", 128'(rnd_key_idx), 128'(7));
    check("rr_rst_readys", 128'({req0_ready, req1_ready}), 128'(0));
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rr_busy_ov", 128'({busy, out_valid}), 128'(0));
    check("rr_rnd_ctl", 128'({rnd_key_idx, rnd_first, rnd_last, rnd_dec}), 128'(0));
    check("rr_rnd_state", rnd_state, '0);
    check("rr_grant", 128'({req0_ready, req1_ready}), 128'(2'b10));
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (20) tick();

    // Mode/data isolation: inputs change after accept
    for (int m = 0; m < 2; m++) begin
      d0 = rand128(); e0 = 1'(m);
      req0_data = d0; req0_encdec = e0; req0_valid = 1'b1;
      wait_ready("iso_wait_ready");
      tick();
      req0_valid = 1'b0; req0_data = ~d0; req0_encdec = ~e0;
      wait_ov("iso_wait_ov");
      check("iso_data", out_data, aes_ref(d0, e0));
      tick();
    end

    // Random traffic with random output backpressure
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      a0 = req0_valid & req0_ready;
      a1 = req1_valid & req1_ready;
      tick();
      if (!req0_valid || a0) begin
        req0_valid = ($urandom_range(0, 3) == 0);
        req0_data = rand128(); req0_encdec = 1'($urandom_range(0, 1));
      end
      if (!req1_valid || a1) begin
        req1_valid = ($urandom_range(0, 3) == 0);
        req1_data = rand128(); req1_encdec = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 2) != 0);
    end
    @(negedge clk);
    a0 = req0_valid & req0_ready;
    a1 = req1_valid & req1_ready;
    tick();
    if (a0) req0_valid = 1'b0;
    if (a1) req1_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 80 && (req0_valid || req1_valid); k++) begin
      @(negedge clk);
      a0 = req0_valid & req0_ready;
      a1 = req1_valid & req1_ready;
      tick();
      if (a0) req0_valid = 1'b0;
      if (a1) req1_valid = 1'b0;
    end
    repeat (40) tick();
    check("drain_pending", 128'(exp_q.size()), 128'(0));
    check("drain_idle", 128'({busy, out_valid}), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
